// File: rtl/scalar_mult_ctrl.sv
// MSB-first double-and-add controller driving an external point add/double engine.
// Optional build macro SMUL_OPCOUNT_EN adds the op_count output (engine ops issued per run).
module scalar_mult_ctrl #(
  parameter int n = 230
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] k,
  input  logic [n-1:0] xp,
  input  logic [n-1:0] yp,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] x_out,
  output logic [n-1:0] y_out,
  output logic         inf_out,
  output logic         op_start,
  output logic         op_dbl,
  output logic [n-1:0] op_x1,
  output logic [n-1:0] op_y1,
  output logic [n-1:0] op_x2,
  output logic [n-1:0] op_y2,
  input  logic [n-1:0] op_x3,
  input  logic [n-1:0] op_y3,
  input  logic         op_result,
  input  logic         op_infinity
`ifdef SMUL_OPCOUNT_EN
  ,
  output logic [15:0]  op_count
`endif
);

  localparam int IW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [2:0] {IDLE, SCAN, DBL_WAIT, ADD_WAIT, DONE} state_t;

  state_t          state, state_next;
  logic [n-1:0]    k_r, px, py, rx, ry;
  logic            acc_inf;
  logic [IW-1:0]   idx;

  logic            cur_bit, eng_done, eng_inf;
  logic [n-1:0]    eng_rx, eng_ry;
  logic            accept, advance, finish, issue, issue_dbl, upd_r, load_p;
  logic [n-1:0]    nx_rx, nx_ry, nx_x1, nx_y1, nx_x2, nx_y2;
  logic            nx_inf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    issue      = 1'b0;
    issue_dbl  = 1'b0;
    upd_r      = 1'b0;
    load_p     = 1'b0;
    cur_bit    = k_r[idx];
    eng_done   = op_result | op_infinity;
    // Infinity wins when the engine raises both completion flags together.
    eng_rx     = rx;
    eng_ry     = ry;
    eng_inf    = acc_inf;
    if (op_infinity) begin
      eng_inf = 1'b1;
    end else if (op_result) begin
      eng_rx = op_x3;
      eng_ry = op_y3;
    end

    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (!acc_inf) begin
          issue      = 1'b1;
          issue_dbl  = 1'b1;
          state_next = DBL_WAIT;
        end else begin
          load_p  = cur_bit;
          advance = 1'b1;
        end
      end
      DBL_WAIT: begin
        if (eng_done) begin
          upd_r = 1'b1;
          if (cur_bit && !eng_inf) begin
            issue      = 1'b1;
            state_next = ADD_WAIT;
          end else begin
            load_p  = cur_bit;
            advance = 1'b1;
          end
        end
      end
      ADD_WAIT: begin
        if (eng_done) begin
          upd_r   = 1'b1;
          advance = 1'b1;
        end
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (advance) state_next = (idx == '0) ? DONE : SCAN;

    nx_rx  = rx;
    nx_ry  = ry;
    nx_inf = acc_inf;
    if (upd_r) begin
      nx_rx  = eng_rx;
      nx_ry  = eng_ry;
      nx_inf = eng_inf;
    end
    if (load_p) begin
      nx_rx  = px;
      nx_ry  = py;
      nx_inf = 1'b0;
    end
    if (accept) nx_inf = 1'b1;

    // Doubling takes R twice; addition takes the freshly doubled R plus the base point.
    nx_x1 = issue_dbl ? rx : eng_rx;
    nx_y1 = issue_dbl ? ry : eng_ry;
    nx_x2 = issue_dbl ? rx : px;
    nx_y2 = issue_dbl ? ry : py;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_r      <= '0;
      px       <= '0;
      py       <= '0;
      rx       <= '0;
      ry       <= '0;
      acc_inf  <= 1'b0;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      x_out    <= '0;
      y_out    <= '0;
      inf_out  <= 1'b0;
      op_start <= 1'b0;
      op_dbl   <= 1'b0;
      op_x1    <= '0;
      op_y1    <= '0;
      op_x2    <= '0;
      op_y2    <= '0;
    end else begin
      rx       <= nx_rx;
      ry       <= nx_ry;
      acc_inf  <= nx_inf;
      op_start <= issue;
      done     <= finish;
      if (accept) begin
        k_r  <= k;
        px   <= xp;
        py   <= yp;
        idx  <= IW'(n - 1);
        busy <= 1'b1;
      end
      if (advance && idx != '0) idx <= idx - 1'b1;
      if (issue) begin
        op_dbl <= issue_dbl;
        op_x1  <= nx_x1;
        op_y1  <= nx_y1;
        op_x2  <= nx_x2;
        op_y2  <= nx_y2;
      end
      if (finish) begin
        x_out   <= rx;
        y_out   <= ry;
        inf_out <= acc_inf;
        busy    <= 1'b0;
      end
    end
  end

`ifdef SMUL_OPCOUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           op_count <= '0;
    else if (accept)                     op_count <= '0;
    else if (issue && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl (n=8) with a 3-cycle behavioural engine in the additive group Z/256 x Z/256.
module tb_scalar_mult_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [N-1:0] k, xp, yp;
  logic         busy, done, inf_out, op_start, op_dbl, op_result, op_infinity;
  logic [N-1:0] x_out, y_out, op_x1, op_y1, op_x2, op_y2, op_x3, op_y3;
`ifdef SMUL_OPCOUNT_EN
  logic [15:0]  op_count;
`endif

  scalar_mult_ctrl #(.n(N)) dut (
    .clk(clk), .reset(reset), .start(start), .k(k), .xp(xp), .yp(yp),
    .busy(busy), .done(done), .x_out(x_out), .y_out(y_out), .inf_out(inf_out),
    .op_start(op_start), .op_dbl(op_dbl),
    .op_x1(op_x1), .op_y1(op_y1), .op_x2(op_x2), .op_y2(op_y2),
    .op_x3(op_x3), .op_y3(op_y3), .op_result(op_result), .op_infinity(op_infinity)
`ifdef SMUL_OPCOUNT_EN
    , .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Engine: doubling = 2*P, addition = P+Q (mod 256); x3==0 means infinity.
  bit           force_add_inf = 1'b0;
  bit           late_req = 1'b0;
  int           eng_ops = 0;
  bit           rec_dbl[$];
  logic [N-1:0] rec_x1[$], rec_y1[$], rec_x2[$], rec_y2[$];

  initial begin : engine
    bit           pend;
    int           cnt;
    bit           ldbl;
    logic [N-1:0] lx1, ly1, lx2, ly2, sx, sy;
    pend = 0; cnt = 0;
    op_result = 0; op_infinity = 0; op_x3 = '0; op_y3 = '0;
    forever begin
      @(posedge clk); #1;
      op_result = 0; op_infinity = 0;
      if (reset) begin
        pend = 0;
      end else if (late_req) begin
        op_result = 1; op_x3 = 8'h5A; op_y3 = 8'hA5;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 0;
          check("operand_stable", {op_dbl, op_x1, op_y1, op_x2, op_y2}, {ldbl, lx1, ly1, lx2, ly2});
          sx = ldbl ? N'(lx1 << 1) : N'(lx1 + lx2);
          sy = ldbl ? N'(ly1 << 1) : N'(ly1 + ly2);
          if (sx == 0 || (force_add_inf && !ldbl)) begin
            op_infinity = 1; op_result = 1; op_x3 = 8'hEE; op_y3 = 8'hEE;
          end else begin
            op_result = 1; op_x3 = sx; op_y3 = sy;
          end
        end
      end
      if (op_start && !reset) begin
        pend = 1; cnt = 3; eng_ops++;
        ldbl = op_dbl; lx1 = op_x1; ly1 = op_y1; lx2 = op_x2; ly2 = op_y2;
        rec_dbl.push_back(op_dbl);
        rec_x1.push_back(op_x1); rec_y1.push_back(op_y1);
        rec_x2.push_back(op_x2); rec_y2.push_back(op_y2);
      end
    end
  end

  // Reference: textbook MSB-first double-and-add over the same group.
  task automatic ref_model(input logic [N-1:0] kk, px, py, input bit finf,
                           output logic [N-1:0] ex, ey, output bit einf, output int eops);
    logic [N-1:0] s;
    einf = 1; ex = 0; ey = 0; eops = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!einf) begin
        eops++;
        s = N'(ex * 2);
        if (s == 0) einf = 1;
        else begin ex = s; ey = N'(ey * 2); end
      end
      if (kk[i]) begin
        if (einf) begin ex = px; ey = py; einf = 0; end
        else begin
          eops++;
          s = N'(ex + px);
          if (finf || s == 0) einf = 1;
          else begin ex = s; ey = N'(ey + py); end
        end
      end
    end
  endtask

  int cyc;
  bit got_done;

  task automatic wait_done();
    cyc = 0; got_done = 0;
    while (!got_done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got_done = 1;
    end
    if (!got_done) check("done_timeout", 0, 1);
  endtask

  task automatic run(input logic [N-1:0] kk, xx, yy, input bit finf);
    force_add_inf = finf;
    eng_ops = 0;
    rec_dbl.delete(); rec_x1.delete(); rec_y1.delete(); rec_x2.delete(); rec_y2.delete();
    @(negedge clk);
    k = kk; xp = xx; yp = yy; start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_done();
  endtask

  task automatic check_result(input string tag, input logic [N-1:0] ex, ey, input bit einf, input int eops);
    check({tag, "_inf"}, inf_out, einf);
    if (!einf) begin
      check({tag, "_x"}, x_out, ex);
      check({tag, "_y"}, y_out, ey);
    end
    check({tag, "_ops"}, eng_ops, eops);
`ifdef SMUL_OPCOUNT_EN
    check({tag, "_op_count"}, op_count, eops);
`endif
  endtask

  typedef struct {
    logic [N-1:0] k, xp, yp;
    bit           finf;
    logic [N-1:0] ex, ey;
    bit           einf;
    int           eops;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [N-1:0] rk, rxp, ryp, ex, ey;
    bit           rf, einf;
    int           eops;
    bit           seen_done;

    tbl[0] = '{8'h00, 8'h11, 8'h22, 1'b0, 8'h00, 8'h00, 1'b1, 0};
    tbl[1] = '{8'h01, 8'h11, 8'h22, 1'b0, 8'h11, 8'h22, 1'b0, 0};
    tbl[2] = '{8'h03, 8'h05, 8'h07, 1'b0, 8'h0F, 8'h15, 1'b0, 2};
    tbl[3] = '{8'h03, 8'h05, 8'h07, 1'b1, 8'h00, 8'h00, 1'b1, 2};
    tbl[4] = '{8'h02, 8'h80, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1};
    tbl[5] = '{8'hFF, 8'h01, 8'h02, 1'b0, 8'hFF, 8'hFE, 1'b0, 14};
    tbl[6] = '{8'h80, 8'h03, 8'h05, 1'b0, 8'h80, 8'h80, 1'b0, 7};

    reset = 1; start = 0; k = '0; xp = '0; yp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_op_start", op_start, 0);
    check("rst_op_dbl", op_dbl, 0);
    check("rst_outs", {inf_out, x_out, y_out}, 0);
    check("rst_operands", {op_x1, op_y1, op_x2, op_y2}, 0);
    @(negedge clk); reset = 0;

    foreach (tbl[i]) begin
      run(tbl[i].k, tbl[i].xp, tbl[i].yp, tbl[i].finf);
      check_result($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].einf, tbl[i].eops);
    end

    // No-op run: done exactly n+1 cycles after the start edge, one cycle wide.
    run(8'h00, 8'h12, 8'h34, 1'b0);
    check("latency_k0", cyc, 9);
    check("busy_at_done", busy, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("result_held", inf_out, 1);

    // k=3: doubling of P then addition of (2P, P).
    run(8'h03, 8'h05, 8'h07, 1'b0);
    check("k3_nops", rec_dbl.size(), 2);
    if (rec_dbl.size() == 2) begin
      check("k3_seq", {rec_dbl[0], rec_dbl[1]}, 2'b10);
      check("k3_dbl_opnd", {rec_x1[0], rec_y1[0], rec_x2[0], rec_y2[0]}, 32'h05070507);
      check("k3_add_opnd", {rec_x1[1], rec_y1[1], rec_x2[1], rec_y2[1]}, 32'h0A0E0507);
    end

    // Start while busy is ignored.
    eng_ops = 0;
    @(negedge clk); k = 8'h01; xp = 8'h11; yp = 8'h22; start = 1;
    @(negedge clk); start = 0;
    repeat (2) @(negedge clk);
    check("busy_mid", busy, 1);
    k = 8'hFF; xp = 8'h33; yp = 8'h44; start = 1;
    @(negedge clk); start = 0;
    wait_done();
    check("busy_start_x", x_out, 8'h11);
    check("busy_start_y", y_out, 8'h22);
    check("busy_start_ops", eng_ops, 0);
    seen_done = 0;
    repeat (12) begin @(posedge clk); #1; if (done || busy) seen_done = 1; end
    check("no_second_run", seen_done, 0);

    // Reset inside DBL_WAIT, then a stale completion.
    eng_ops = 0;
    @(negedge clk); k = 8'h03; xp = 8'h05; yp = 8'h07; start = 1;
    @(negedge clk); start = 0;
    cyc = 0;
    while (eng_ops == 0 && cyc < 100) begin @(negedge clk); cyc++; end
    check("reached_dbl_wait", eng_ops, 1);
    reset = 1; #1;
    check("async_rst_busy", {busy, op_start, op_dbl}, 0);
    @(negedge clk); reset = 0;
    late_req = 1;
    @(negedge clk); late_req = 0;
    seen_done = 0;
    repeat (12) begin @(posedge clk); #1; if (done || busy || op_start) seen_done = 1; end
    check("late_ignored", seen_done, 0);
    check("late_outs", {inf_out, x_out, y_out}, 0);
    check("late_operands", {op_dbl, op_x1, op_y1, op_x2, op_y2}, 0);

    for (int i = 0; i < 24; i++) begin
      rk  = N'($urandom_range(0, 255));
      rxp = N'($urandom_range(1, 255));
      ryp = N'($urandom_range(0, 255));
      rf  = ($urandom_range(0, 7) == 0);
      ref_model(rk, rxp, ryp, rf, ex, ey, einf, eops);
      run(rk, rxp, ryp, rf);
      check_result($sformatf("rnd%0d_k%0h", i, rk), ex, ey, einf, eops);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scalar_mult_ctrl.md
SCALAR_MULT_CTRL -- requirements
Module: scalar_mult_ctrl

Interface
REQ-001 SHALL have parameter n, default 230, giving the coordinate and scalar width in bits.
REQ-002 SHALL have ports: clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have ports: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have ports: k  input  n  scalar; xp, yp  input  n each  affine base point.
REQ-006 SHALL have ports: busy  output  1  high from the cycle after an accepted start until done.
REQ-007 SHALL have ports: done  output  1  one-cycle result strobe; x_out, y_out  output  n each  result; inf_out  output  1  result is the point at infinity.
REQ-008 SHALL have engine ports: op_start  output  1  one-cycle engine restart pulse; op_dbl  output  1  0=add, 1=double.
REQ-009 SHALL have engine ports: op_x1, op_y1, op_x2, op_y2  output  n each  operands; op_x3, op_y3  input  n each  engine result; op_result, op_infinity  input  1 each  engine completion flags.

Function
REQ-010 SHALL compute k*(xp,yp) by MSB-first double-and-add over all n bits of k, using accumulator R with flag acc_inf.
REQ-011 SHALL use FSM states IDLE, SCAN, DBL_WAIT, ADD_WAIT, DONE.
REQ-012 IDLE: on start=1, SHALL latch k, xp and yp, set acc_inf=1 and bit index to n-1, and enter SCAN.
REQ-013 SCAN, acc_inf=0: SHALL pulse op_start with op_dbl=1 and op_x1=op_x2=Rx, op_y1=op_y2=Ry, then enter DBL_WAIT.
REQ-014 SCAN, acc_inf=1, bit=1: SHALL load R=(xp,yp) and clear acc_inf in one cycle without issuing an engine op, then advance the bit index.
REQ-015 SCAN, acc_inf=1, bit=0: SHALL only advance the bit index, taking one cycle.
REQ-016 DBL_WAIT: on op_result SHALL load R from (op_x3, op_y3); on op_infinity SHALL set acc_inf=1.
REQ-017 DBL_WAIT exit: if the bit is 1 and acc_inf=0, SHALL pulse op_start with op_dbl=0, (op_x1,op_y1)=R, (op_x2,op_y2)=(xp,yp), and enter ADD_WAIT.
REQ-018 DBL_WAIT exit otherwise: if the bit is 1 and acc_inf=1, SHALL load R=(xp,yp) and clear acc_inf; in every other case it SHALL only advance the bit index.
REQ-019 ADD_WAIT: SHALL update R or acc_inf as in REQ-016, then advance the bit index.
REQ-020 Advancing past bit 0 SHALL enter DONE; otherwise the FSM SHALL return to SCAN.
REQ-021 DONE: SHALL drive x_out=Rx, y_out=Ry and inf_out=acc_inf, assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-022 x_out, y_out and inf_out SHALL hold their values until the next done.
REQ-023 If op_result and op_infinity are both high in the same cycle, op_infinity SHALL take priority.
REQ-024 op_result and op_infinity SHALL be ignored outside DBL_WAIT and ADD_WAIT.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 Operand outputs SHALL stay stable from op_start until the matching completion flag is received.
REQ-027 With no engine ops, latency from the start edge to done SHALL be n+1 cycles.

Reset
REQ-028 reset=1 SHALL force IDLE immediately, mid-operation included.
REQ-029 Under reset, busy, done, op_start, op_dbl, inf_out and acc_inf SHALL be 0, and all n-bit outputs and internal registers SHALL be 0.
REQ-030 An engine completion arriving after reset deasserts SHALL be ignored.

Configuration
REQ-031 Macro SMUL_OPCOUNT_EN defined: SHALL add output op_count [15:0], reporting how many engine ops were issued.
REQ-032 op_count SHALL clear on an accepted start, increment on each op_start, saturate at 16'hFFFF, and hold its value after done.
REQ-033 Macro SMUL_OPCOUNT_EN undefined: the op_count port and its counter SHALL be absent, with all other behaviour identical.

Verification (n=8, behavioural engine with 3-cycle latency)
REQ-034 k=8'h00 -> inf_out=1, no op_start, done 9 cycles after the start edge.
REQ-035 k=8'h01, P=(8'h11,8'h22) -> x_out=8'h11, y_out=8'h22, inf_out=0, no op_start.
REQ-036 k=8'h03 -> exactly two engine ops with op_dbl sequence 1,0; add operands are (2P, P); op_count=2.
REQ-037 k=8'h03, engine returns op_infinity on the add -> inf_out=1 at done.
REQ-038 start pulsed while busy -> ignored, first result unchanged.
REQ-039 reset asserted in DBL_WAIT, then a late op_result -> FSM stays in IDLE, all outputs 0, no done.
